// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
//   CHANNELS (= 2**SEL_BITS) independent divide counters producing per-channel
//   tick strobes. Each channel is reprogrammed through one valid/ready port
//   that feeds a single pending slot. The slot is applied to its target channel
//   only when that channel is disabled, at its terminal count, or on a global
//   sync edge, so a running output never sees a truncated or stretched period.
//
// Ports
//   clk            : sole clock, posedge
//   rst            : synchronous active-high reset
//   cfg_valid      : configuration request present
//   cfg_ready      : pending slot empty; transfer on cfg_valid && cfg_ready
//   cfg_sel        : target channel
//   cfg_divideby   : terminal count (period = cfg_divideby + 1 cycles)
//   cfg_pulsemode  : 1 = one-cycle pulse per period, 0 = toggle per period
//   cfg_enable     : channel enable after the update
//   sync           : one-cycle strobe that restarts every enabled channel
//   tick           : per-channel divided output (registered)
//   active         : per-channel applied enable (registered)
// -----------------------------------------------------------------------------
module tick_scheduler #(
  parameter int SEL_BITS = 2,
  parameter int REG_SIZE = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [SEL_BITS-1:0]        cfg_sel,
  input  logic [REG_SIZE-1:0]        cfg_divideby,
  input  logic                       cfg_pulsemode,
  input  logic                       cfg_enable,
  input  logic                       sync,
  output logic [(2**SEL_BITS)-1:0]   tick,
  output logic [(2**SEL_BITS)-1:0]   active
);

  localparam int CHANNELS = 2**SEL_BITS;

  // Per-channel applied state
  logic [REG_SIZE-1:0] r_cnt [CHANNELS];
  logic [REG_SIZE-1:0] r_div [CHANNELS];
  logic [CHANNELS-1:0] r_mode;
  logic [CHANNELS-1:0] r_en;
  logic [CHANNELS-1:0] r_tick;

  // Pending configuration slot
  logic [SEL_BITS-1:0] r_psel;
  logic [REG_SIZE-1:0] r_pdiv;
  logic                r_pmode;
  logic                r_pen;
  logic                r_pvalid;

  logic [CHANNELS-1:0] w_term;
  logic                w_accept;
  logic                w_apply;

  // Output of a channel reaching terminal count: pulse mode fires, toggle
  // mode flips.
  function automatic logic f_term_tick(input logic mode, input logic cur);
    return mode ? 1'b1 : ~cur;
  endfunction

  always_comb begin
    w_term = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_term[i] = (r_cnt[i] == r_div[i]);
    end
  end

  // A request can only be accepted while the slot is empty and can only be
  // applied while it is full, so accept and apply never share an edge.
  assign w_accept  = cfg_valid && !r_pvalid;
  assign w_apply   = r_pvalid && (!r_en[r_psel] || w_term[r_psel] || sync);
  assign cfg_ready = ~r_pvalid;

  // Pending slot: only the valid flag needs reset; payload is qualified by it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pvalid <= 1'b0;
    end else if (w_accept) begin
      r_pvalid <= 1'b1;
    end else if (w_apply) begin
      r_pvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_psel  <= cfg_sel;
      r_pdiv  <= cfg_divideby;
      r_pmode <= cfg_pulsemode;
      r_pen   <= cfg_enable;
    end
  end

  // Channel counters and outputs
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        r_cnt[i]  <= '0;
        r_div[i]  <= '0;
        r_mode[i] <= 1'b1;
        r_en[i]   <= 1'b0;
        r_tick[i] <= 1'b0;
      end else if (w_apply && (r_psel == SEL_BITS'(i))) begin
        r_div[i]  <= r_pdiv;
        r_mode[i] <= r_pmode;
        r_en[i]   <= r_pen;
        r_cnt[i]  <= '0;
        // An enabled channel only reaches here without sync at its terminal
        // count, so the old mode's terminal action keeps the period intact.
        if (sync || !r_pen || !r_en[i]) begin
          r_tick[i] <= 1'b0;
        end else begin
          r_tick[i] <= f_term_tick(r_mode[i], r_tick[i]);
        end
      end else if (!r_en[i] || sync) begin
        r_cnt[i]  <= '0;
        r_tick[i] <= 1'b0;
      end else if (w_term[i]) begin
        r_cnt[i]  <= '0;
        r_tick[i] <= f_term_tick(r_mode[i], r_tick[i]);
      end else begin
        r_cnt[i] <= r_cnt[i] + REG_SIZE'(1);
        if (r_mode[i]) begin
          r_tick[i] <= 1'b0;
        end
      end
    end
  end

  assign tick   = r_tick;
  assign active = r_en;

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

  localparam int SB = 2;
  localparam int RS = 16;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [SB-1:0] cfg_sel;
  logic [RS-1:0] cfg_divideby;
  logic          cfg_pulsemode;
  logic          cfg_enable;
  logic          sync;
  logic [CH-1:0] tick;
  logic [CH-1:0] active;

  tick_scheduler #(.SEL_BITS(SB), .REG_SIZE(RS)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_sel      (cfg_sel),
    .cfg_divideby (cfg_divideby),
    .cfg_pulsemode(cfg_pulsemode),
    .cfg_enable   (cfg_enable),
    .sync         (sync),
    .tick         (tick),
    .active       (active)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int sel;
    int div;
    bit pulse;
    bit en;
  } req_t;

  req_t m_q[$];
  int   m_cnt   [CH];
  int   m_div   [CH];
  bit   m_pulse [CH];
  bit   m_en    [CH];
  bit   m_tick  [CH];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  function automatic logic [CH-1:0] m_tick_vec();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_tick[i];
    return v;
  endfunction

  function automatic logic [CH-1:0] m_act_vec();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_en[i];
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Advance one clock: derive the model's next state from the inputs that the
  // DUT will sample on this edge, then commit it after the edge.
  task automatic step();
    int   nc [CH];
    int   nd [CH];
    bit   np [CH];
    bit   ne [CH];
    bit   nt [CH];
    bit   rdy, do_pop, do_push, do_clr;
    req_t p, r;
    rdy = (m_q.size() == 0);
    nc = m_cnt; nd = m_div; np = m_pulse; ne = m_en; nt = m_tick;
    do_pop = 0; do_push = 0; do_clr = 0;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        nc[i] = 0; nd[i] = 0; np[i] = 1; ne[i] = 0; nt[i] = 0;
      end
      do_clr = 1;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (!m_en[i] || sync) begin
          nc[i] = 0; nt[i] = 0;
        end else if (m_cnt[i] == m_div[i]) begin
          nc[i] = 0; nt[i] = m_pulse[i] ? 1'b1 : !m_tick[i];
        end else begin
          nc[i] = m_cnt[i] + 1;
          if (m_pulse[i]) nt[i] = 0;
        end
      end
      if (m_q.size() > 0) begin
        p = m_q[0];
        if (!m_en[p.sel] || m_cnt[p.sel] == m_div[p.sel] || sync) begin
          nd[p.sel] = p.div; np[p.sel] = p.pulse; ne[p.sel] = p.en; nc[p.sel] = 0;
          if (!p.en) nt[p.sel] = 0;
          do_pop = 1;
        end
      end
      if (cfg_valid && rdy) begin
        r.sel = int'(cfg_sel); r.div = int'(cfg_divideby);
        r.pulse = cfg_pulsemode; r.en = cfg_enable;
        do_push = 1;
      end
    end
    @(posedge clk);
    #1;
    m_cnt = nc; m_div = nd; m_pulse = np; m_en = ne; m_tick = nt;
    if (do_clr) m_q.delete();
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(r);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_tick", tick, m_tick_vec());
      check("cyc_active", active, m_act_vec());
      check("cyc_ready", cfg_ready, (m_q.size() == 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic cfg(input int s, input int d, input bit p, input bit e);
    cfg_valid = 1; cfg_sel = SB'(s); cfg_divideby = RS'(d);
    cfg_pulsemode = p; cfg_enable = e;
    step();
    cfg_valid = 0;
  endtask

  task automatic wait_bit(input int ch, input logic val, input int maxn, output int n);
    n = 0;
    while (tick[ch] !== val && n < maxn) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ready(input int maxn, output int n);
    n = 0;
    while (cfg_ready !== 1'b1 && n < maxn) begin
      step();
      n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, hits, f0, f3;
    logic prev;
    rst = 1; cfg_valid = 0; cfg_sel = '0; cfg_divideby = '0;
    cfg_pulsemode = 0; cfg_enable = 0; sync = 0;
    step();
    chk_on = 1;
    step();
    check("rst_ready", cfg_ready, 1);
    check("rst_tick", tick, 0);
    check("rst_active", active, 0);
    rst = 0;

    // ch0: div=3 pulse, disabled target applies one edge after acceptance
    cfg(0, 3, 1, 1);
    check("s1_ready_low", cfg_ready, 0);
    step();
    check("s1_ready_back", cfg_ready, 1);
    check("s1_active0", active[0], 1);
    check("s1_tick_apply", tick[0], 0);
    wait_bit(0, 1'b1, 20, n);
    check("s1_first_pulse", n, 4);
    hits = 0;
    repeat (8) begin step(); hits += int'(tick[0]); end
    check("s1_pulses_in_8", hits, 2);

    // ch1: div=2 toggle, then div=0 requested mid-period
    cfg(1, 2, 0, 1);
    step();
    check("s2_active1", active[1], 1);
    check("s2_tick_apply", tick[1], 0);
    wait_bit(1, 1'b1, 20, n);
    check("s2_first_toggle", n, 3);
    cfg(1, 0, 0, 1);
    wait_ready(20, n);
    check("s2_ready_low", n, 2);
    check("s2_tick_after_apply", tick[1], 0);
    prev = tick[1]; hits = 0;
    repeat (4) begin
      step();
      if (tick[1] !== prev) hits++;
      prev = tick[1];
    end
    check("s2_toggles_in_4", hits, 4);

    // ch2: div=9 running, div=4 requested with cnt becoming 2
    cfg(2, 9, 1, 1);
    step();
    step();
    cfg(2, 4, 1, 1);
    check("s3_ready_low", cfg_ready, 0);
    cfg_valid = 1; cfg_sel = 2'd3; cfg_divideby = 16'd1;
    cfg_pulsemode = 1; cfg_enable = 1;
    run(3);
    cfg_valid = 0;
    wait_ready(20, n);
    check("s3_ready_low_cycles", n + 3, 8);
    check("s3_second_req_ignored", active[3], 0);
    check("s3_tick_on_apply", tick[2], 1);
    step();
    wait_bit(2, 1'b1, 20, n);
    check("s3_new_period", n + 1, 5);

    // ch0 div=5, ch3 div=7, then sync
    cfg(0, 5, 1, 1);
    wait_ready(20, n);
    cfg(3, 7, 1, 1);
    step();
    run(3);
    sync = 1;
    step();
    sync = 0;
    check("s4_sync_tick0", tick[0], 0);
    check("s4_sync_tick3", tick[3], 0);
    f0 = -1; f3 = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (tick[0] === 1'b1 && f0 < 0) f0 = k;
      if (tick[3] === 1'b1 && f3 < 0) f3 = k;
    end
    check("s4_first_pulse0", f0, 6);
    check("s4_first_pulse3", f3, 8);
    cfg(3, 2, 1, 1);
    check("s4_pending_held", cfg_ready, 0);
    sync = 1;
    step();
    sync = 0;
    check("s4_sync_apply_ready", cfg_ready, 1);
    check("s4_sync_apply_tick", tick[3], 0);
    check("s4_sync_apply_active", active[3], 1);
    wait_bit(3, 1'b1, 20, n);
    check("s4_new_pulse3", n, 3);

    // ch1: disable while tick is high, then re-enable
    wait_bit(1, 1'b0, 4, n);
    cfg(1, 0, 0, 0);
    check("s5_tick_high_before", tick[1], 1);
    step();
    check("s5_tick_off", tick[1], 0);
    check("s5_active_off", active[1], 0);
    run(5);
    check("s5_tick_stays", tick[1], 0);
    check("s5_active_stays", active[1], 0);
    cfg(1, 2, 0, 1);
    step();
    check("s5_reenable", active[1], 1);
    wait_bit(1, 1'b1, 20, n);
    check("s5_restart_cnt", n, 3);

    // reset with an update pending on ch2
    wait_bit(2, 1'b1, 20, n);
    cfg(2, 9, 0, 1);
    check("s6_pending", cfg_ready, 0);
    rst = 1;
    step();
    check("s6_rst_ready", cfg_ready, 1);
    check("s6_rst_tick", tick, 0);
    check("s6_rst_active", active, 0);
    rst = 0;
    run(20);
    check("s6_never_applied", active, 0);
    check("s6_tick_idle", tick, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Programmable multi-channel tick generator and configuration controller for the system's clock-division datapath. It owns CHANNELS independent divide counters. Each counter is reconfigured at run time through a single valid/ready configuration port. Updates are applied glitch-free, only at the target channel's terminal count or while that channel is disabled. A global sync input realigns the phase of all channels, so peripheral strobes (UART baud, timers, display refresh) can be retuned and aligned without stopping the core clock.

## Interface
- SEL_BITS, 2: channel-select width; CHANNELS = 2**SEL_BITS.
- REG_SIZE, 16: width of each divide counter and of cfg_divideby.
- clk  in  1: sole clock, all logic on posedge.
- rst  in  1: synchronous, active-high reset.
- cfg_valid  in  1: configuration request present.
- cfg_ready  out  1: scheduler can accept a request; transfer occurs when cfg_valid && cfg_ready at a posedge.
- cfg_sel  in  SEL_BITS: target channel.
- cfg_divideby  in  REG_SIZE: terminal count; period is cfg_divideby+1 cycles.
- cfg_pulsemode  in  1: 1 = single-cycle pulse per period, 0 = toggle per period (50% duty, period 2*(div+1)).
- cfg_enable  in  1: channel enable after update.
- sync  in  1: single-cycle phase-realign strobe.
- tick  out  CHANNELS: per-channel divided output, registered.
- active  out  CHANNELS: registered copy of each channel's applied enable.

## Operation
- Per channel i, registered state: cnt[i], div[i], mode[i], en[i], tick[i].
- Enabled channel, each cycle:
  - If cnt == div (terminal): cnt <= 0. Pulse mode: tick <= 1. Toggle mode: tick <= ~tick.
  - Otherwise: cnt <= cnt+1. Pulse mode: tick <= 0. Toggle mode: tick holds.
  - Counter arithmetic is unsigned REG_SIZE. cnt never exceeds div, so there is no wrap past div.
- Disabled channel: cnt held at 0, tick held at 0.
- div = 0: terminal every cycle. Pulse mode gives tick constantly 1; toggle mode inverts every cycle.
- Configuration uses a single pending slot (psel, pdiv, pmode, pen, pvalid):
  - Accepting a request loads the slot and drops cfg_ready.
  - Apply condition: the target channel is disabled, or its cnt == div, or sync is high.
  - On the apply edge: div, mode and en take the new values, cnt <= 0, and pvalid clears.
  - tick on the apply edge:
    - new en = 0: tick <= 0.
    - Channel was disabled: tick <= 0.
    - Otherwise: tick takes the terminal action of the old mode.
  - New settings govern counting from the following cycle.
- Apply is never evaluated on the same edge the request is accepted. It is evaluated from the next edge on.
- sync has priority over normal counting. On an edge with sync high:
  - Every enabled channel: cnt <= 0, tick <= 0.
  - Any pending update applies on that same edge, with tick <= 0.
  - A request accepted on a sync edge waits for a later apply condition.
- Channels not targeted by the pending slot are unaffected by configuration traffic.

## Timing
- Reset values:
  - cnt = 0, div = 0, mode = 1, en = 0 on all channels.
  - tick = 0, active = 0.
  - pvalid = 0, cfg_ready = 1.
- rst asserted mid-operation discards any pending update and overrides sync and cfg_valid.
- cfg_ready is driven as ~pvalid from a register. It returns to 1 the cycle after the apply edge, so at most one request is in flight.
- Apply latency depends on the target channel's state at acceptance:
  - Disabled target: applies on the 1st edge after acceptance.
  - Enabled target: applies at its next terminal count, worst case div+1 edges after acceptance.
- active[i] updates on the apply edge. tick[i] latency from an enabled apply to the first pulse is div+1 cycles.

## Test plan
- Reset, then write ch0 with div=3, pulse, en=1: tick[0] first goes high 4 cycles after the apply edge, then is high 1 of every 4 cycles. cfg_ready is low for exactly 1 cycle.
- ch1 with div=2, toggle, enabled: tick[1] inverts every 3 cycles, period 6. Write div=0 mid-period: the old period completes before the update takes effect, after which tick[1] inverts every cycle.
- ch2 running with div=9. Request div=4 at cnt=2: cfg_ready stays low 8 cycles, apply occurs when cnt==9, and the new pulse period is 5. A second cfg_valid during the wait is not accepted.
- ch0 div=5, ch3 div=7, both enabled. Pulse sync: both counters restart, tick=0 on the sync edge, and both first pulses follow at cycles 6 and 8. With a pending update held for ch3, the update applies on the sync edge.
- Disable a running toggle channel whose tick=1: on the apply edge tick goes to 0 and active bit goes to 0, and they stay 0. Re-enable: active goes to 1 and cnt starts at 0.
- Assert rst while an update is pending: cfg_ready=1, all tick=0, all active=0. The pending config is never applied.
